j1_io_fabric: RTL and testbench

Parametrised I/O interconnect between the J1 CPU I/O port and up to NSLOTS memory-mapped peripherals. It decodes a page field of the I/O address into one-hot chip-selects and drives a registered read-data mux. Unlike the plain combinational decoder, it runs a per-access handshake with slave ready, wait-state stall, timeout and unmapped-address detection. It also provides a small internal status page: sticky error register and access counter.

---
 rtl/j1_io_fabric.sv | 170 +++++++++++++++++
 tb/tb_j1_io_fabric.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/j1_io_fabric.sv
// J1 I/O interconnect: page decode to NSLOTS peripherals with ready/timeout handshake,
// registered read mux, and an internal status page (sticky errors, access counter).
module j1_io_fabric #(
  parameter int unsigned    NSLOTS       = 4,
  parameter int unsigned    DW           = 16,
  parameter int unsigned    SUB_AW       = 4,
  parameter logic [7:0]     BASE_PAGE    = 8'h67,
  parameter logic [7:0]     FABRIC_PAGE  = 8'hFF,
  parameter int unsigned    TIMEOUT      = 15,
  parameter logic [DW-1:0]  DEFAULT_DATA = DW'(16'h0666)
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [15:0]          m_addr,
  input  logic                 m_rd,
  input  logic                 m_wr,
  input  logic [DW-1:0]        m_dout,
  output logic [DW-1:0]        m_din,
  output logic                 m_stall,
  output logic [NSLOTS-1:0]    s_cs,
  output logic [SUB_AW-1:0]    s_addr,
  output logic                 s_rd,
  output logic                 s_wr,
  output logic [DW-1:0]        s_din,
  input  logic [NSLOTS*DW-1:0] s_dout,
  input  logic [NSLOTS-1:0]    s_ready,
  output logic                 irq_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        slot;
  logic [7:0]        cnt;
  logic              is_wr;
  logic              count_en;
  logic [15:0]       acc_count;
  logic [3:0]        err_slot, err_slot_nxt;
  logic [1:0]        err_bits, err_bits_nxt;
  logic [15:0]       err_word;

  logic [7:0]        page, diff;
  logic [SUB_AW-1:0] idx;
  logic              req, is_fab, is_hit, timeout_hit;
  logic [DW-1:0]     rdata;
  logic              ready_sel;
  logic [NSLOTS-1:0] cs_vec;
  logic              unused_addr;

  assign page        = m_addr[15:8];
  assign diff        = page - BASE_PAGE;
  assign idx         = m_addr[SUB_AW-1:0];
  assign req         = m_rd | m_wr;
  assign is_fab      = (page == FABRIC_PAGE);
  assign is_hit      = !is_fab && (32'(diff) < NSLOTS);
  assign err_word    = {8'h00, err_slot, 2'b00, err_bits};
  assign unused_addr = ^m_addr[7:SUB_AW];

  // Slot-indexed views of the slave buses, selected by the latched slot field.
  always_comb begin
    rdata     = '0;
    ready_sel = 1'b0;
    cs_vec    = '0;
    for (int unsigned k = 0; k < NSLOTS; k++) begin
      if (slot == 4'(k)) begin
        rdata     = s_dout[k*DW +: DW];
        ready_sel = s_ready[k];
        cs_vec[k] = 1'b1;
      end
    end
  end

  assign timeout_hit = (state == ACCESS) && !ready_sel && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = is_hit ? ACCESS : DONE;
      ACCESS:  if (ready_sel || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cs    = (state == ACCESS) ? cs_vec : '0;
    s_rd    = (state == ACCESS) && (cnt == 8'd0) && !is_wr;
    s_wr    = (state == ACCESS) && (cnt == 8'd0) && is_wr;
    m_stall = ((state == IDLE) && req) || (state == ACCESS);
  end

  // Read-clear is applied first so an error raised in the same cycle is kept.
  always_comb begin
    err_slot_nxt = err_slot;
    err_bits_nxt = err_bits;
    if ((state == IDLE) && req && is_fab && !m_wr && (idx == SUB_AW'(0))) begin
      err_slot_nxt = 4'h0;
      err_bits_nxt = 2'b00;
    end
    if ((state == IDLE) && req && !is_fab && !is_hit) begin
      err_slot_nxt = 4'hF;
      err_bits_nxt = err_bits_nxt | 2'b10;
    end
    if (timeout_hit) begin
      err_slot_nxt = slot;
      err_bits_nxt = err_bits_nxt | 2'b01;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      m_din     <= '0;
      s_addr    <= '0;
      s_din     <= '0;
      slot      <= '0;
      cnt       <= '0;
      is_wr     <= 1'b0;
      count_en  <= 1'b0;
      acc_count <= '0;
      err_slot  <= '0;
      err_bits  <= '0;
      irq_err   <= 1'b0;
    end else begin
      err_slot <= err_slot_nxt;
      err_bits <= err_bits_nxt;
      irq_err  <= |err_bits_nxt;
      case (state)
        IDLE: if (req) begin
          is_wr    <= m_wr;
          count_en <= 1'b1;
          if (is_fab) begin
            if (m_wr) begin
              m_din <= DEFAULT_DATA;
              if (idx == SUB_AW'(1)) begin
                acc_count <= 16'(m_dout);
                count_en  <= 1'b0;
              end
            end else if (idx == SUB_AW'(0)) begin
              m_din <= DW'(err_word);
            end else if (idx == SUB_AW'(1)) begin
              m_din <= DW'(acc_count);
            end else begin
              m_din <= DEFAULT_DATA;
            end
          end else if (is_hit) begin
            slot   <= diff[3:0];
            s_addr <= idx;
            s_din  <= m_dout;
            cnt    <= '0;
          end else begin
            m_din <= DEFAULT_DATA;
          end
        end
        ACCESS: begin
          if (ready_sel)        m_din <= is_wr ? DEFAULT_DATA : rdata;
          else if (timeout_hit) m_din <= DEFAULT_DATA;
          else                  cnt   <= cnt + 8'd1;
        end
        DONE: if (count_en) acc_count <= acc_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_io_fabric.sv
// Directed self-checking bench for j1_io_fabric: slot reads/writes, wait states,
// timeout, unmapped decode, status page, counter wrap and async reset.
module tb_j1_io_fabric;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] m_addr = '0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_din;
  logic        m_stall;
  logic [3:0]  s_cs;
  logic [3:0]  s_addr;
  logic        s_rd;
  logic        s_wr;
  logic [15:0] s_din;
  logic [63:0] s_dout = '0;
  logic [3:0]  s_ready = '0;
  logic        irq_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  j1_io_fabric #(
    .NSLOTS(4), .DW(16), .SUB_AW(4), .BASE_PAGE(8'h67), .FABRIC_PAGE(8'hFF),
    .TIMEOUT(15), .DEFAULT_DATA(16'h0666)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_dout(m_dout),
    .m_din(m_din), .m_stall(m_stall),
    .s_cs(s_cs), .s_addr(s_addr), .s_rd(s_rd), .s_wr(s_wr), .s_din(s_din),
    .s_dout(s_dout), .s_ready(s_ready), .irq_err(irq_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master();
    m_rd = 1'b0;
    m_wr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_din !== 16'h0000) begin failures++; $display("FAIL reset_m_din got=%h exp=0000", m_din); end
    checks++; if ({s_cs, s_rd, s_wr, m_stall, irq_err} !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {s_cs, s_rd, s_wr, m_stall, irq_err}); end
    checks++; if ({s_addr, s_din} !== 20'h0) begin failures++; $display("FAIL reset_regs got=%h exp=00000", {s_addr, s_din}); end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_read_slot2();
    m_addr = 16'h6903; m_rd = 1'b1; s_dout[2*16 +: 16] = 16'hBEEF; s_ready = 4'b0100;
    #1;
    checks++; if (m_stall !== 1'b1) begin failures++; $display("FAIL rd2_stall_idle got=%b exp=1", m_stall); end
    tick();
    checks++; if ({s_cs, s_addr, s_rd, s_wr, m_stall} !== {4'b0100, 4'h3, 3'b101}) begin failures++; $display("FAIL rd2_access got=%b exp=%b", {s_cs, s_addr, s_rd, s_wr, m_stall}, {4'b0100, 4'h3, 3'b101}); end
    tick();
    checks++; if (m_din !== 16'hBEEF) begin failures++; $display("FAIL rd2_data got=%h exp=beef", m_din); end
    checks++; if ({s_cs, s_rd, m_stall} !== 6'b0) begin failures++; $display("FAIL rd2_done got=%b exp=000000", {s_cs, s_rd, m_stall}); end
    idle_master(); s_ready = '0;
    tick();
    m_addr = 16'hFF01; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h0001) begin failures++; $display("FAIL rd2_acc_count got=%h exp=0001", m_din); end
    idle_master();
    tick();
  endtask

  task automatic test_write_wait();
    m_addr = 16'h6700; m_wr = 1'b1; m_dout = 16'h1234; s_ready = '0;
    tick();
    checks++; if ({s_cs, s_wr, s_rd, s_din} !== {4'b0001, 2'b10, 16'h1234}) begin failures++; $display("FAIL wr0_first got=%h exp=%h", {s_cs, s_wr, s_rd, s_din}, {4'b0001, 2'b10, 16'h1234}); end
    tick();
    checks++; if ({s_cs, s_wr, m_stall} !== {4'b0001, 2'b01}) begin failures++; $display("FAIL wr0_wait1 got=%b exp=000101", {s_cs, s_wr, m_stall}); end
    tick();
    tick();
    checks++; if ({s_cs, m_stall} !== {4'b0001, 1'b1}) begin failures++; $display("FAIL wr0_wait3 got=%b exp=00011", {s_cs, m_stall}); end
    s_ready = 4'b0001;
    tick();
    checks++; if ({m_din, s_cs, m_stall} !== {16'h0666, 5'b0}) begin failures++; $display("FAIL wr0_done got=%h exp=%h", {m_din, s_cs, m_stall}, {16'h0666, 5'b0}); end
    idle_master(); s_ready = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    m_addr = 16'h6800; m_rd = 1'b1; s_ready = 4'b1101;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_cs == 4'b0010) n++;
      else break;
    end
    checks++; if (n !== 15) begin failures++; $display("FAIL to_cycles got=%0d exp=15", n); end
    checks++; if ({m_din, m_stall, irq_err} !== {16'h0666, 2'b01}) begin failures++; $display("FAIL to_done got=%h exp=%h", {m_din, m_stall, irq_err}, {16'h0666, 2'b01}); end
    idle_master(); s_ready = '0;
    tick();
    m_addr = 16'hFF00; m_rd = 1'b1;
    tick();
    checks++; if ({m_din, irq_err} !== {16'h0011, 1'b0}) begin failures++; $display("FAIL to_status got=%h exp=%h", {m_din, irq_err}, {16'h0011, 1'b0}); end
    idle_master();
    tick();
    m_addr = 16'hFF00; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h0000) begin failures++; $display("FAIL to_cleared got=%h exp=0000", m_din); end
    idle_master();
    tick();
  endtask

  task automatic test_unmapped();
    m_addr = 16'h7A00; m_rd = 1'b1;
    #1;
    checks++; if ({m_stall, s_cs} !== 5'b10000) begin failures++; $display("FAIL um_idle got=%b exp=10000", {m_stall, s_cs}); end
    tick();
    checks++; if ({m_din, m_stall, s_cs, irq_err} !== {16'h0666, 6'b000001}) begin failures++; $display("FAIL um_done got=%h exp=%h", {m_din, m_stall, s_cs, irq_err}, {16'h0666, 6'b000001}); end
    idle_master();
    tick();
    m_addr = 16'hFF00; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h00F2) begin failures++; $display("FAIL um_status got=%h exp=00f2", m_din); end
    idle_master();
    tick();
  endtask

  task automatic test_counter_wrap();
    m_addr = 16'hFF01; m_wr = 1'b1; m_dout = 16'hFFFF;
    tick();
    checks++; if (m_din !== 16'h0666) begin failures++; $display("FAIL wrap_wr_data got=%h exp=0666", m_din); end
    idle_master();
    tick();
    m_addr = 16'h6A00; m_rd = 1'b1; s_dout[3*16 +: 16] = 16'hCAFE; s_ready = 4'b1000;
    tick();
    tick();
    checks++; if (m_din !== 16'hCAFE) begin failures++; $display("FAIL wrap_rd3 got=%h exp=cafe", m_din); end
    idle_master(); s_ready = '0;
    tick();
    m_addr = 16'h6705; m_rd = 1'b1; m_wr = 1'b1; m_dout = 16'h5A5A; s_ready = 4'b0001;
    tick();
    checks++; if ({s_addr, s_wr, s_rd, s_din} !== {4'h5, 2'b10, 16'h5A5A}) begin failures++; $display("FAIL wrap_rdwr got=%h exp=%h", {s_addr, s_wr, s_rd, s_din}, {4'h5, 2'b10, 16'h5A5A}); end
    tick();
    idle_master(); s_ready = '0;
    tick();
    m_addr = 16'hFF01; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h0001) begin failures++; $display("FAIL wrap_count got=%h exp=0001", m_din); end
    idle_master();
    tick();
    m_addr = 16'hFF05; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h0666) begin failures++; $display("FAIL fab_other got=%h exp=0666", m_din); end
    idle_master();
    tick();
  endtask

  task automatic test_async_reset();
    m_addr = 16'h6800; m_rd = 1'b1; s_ready = '0;
    tick();
    checks++; if ({s_cs, s_rd} !== 5'b00101) begin failures++; $display("FAIL ar_pre got=%b exp=00101", {s_cs, s_rd}); end
    #2;
    rst = 1'b1; m_rd = 1'b0;
    #1;
    checks++; if ({s_cs, s_rd, m_stall, m_din} !== 22'h0) begin failures++; $display("FAIL ar_immediate got=%h exp=000000", {s_cs, s_rd, m_stall, m_din}); end
    @(negedge clk) rst = 1'b0;
    tick();
    m_addr = 16'hFF01; m_rd = 1'b1;
    tick();
    checks++; if (m_din !== 16'h0000) begin failures++; $display("FAIL ar_count got=%h exp=0000", m_din); end
    idle_master();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_slot2();
    test_write_wait();
    test_timeout();
    test_unmapped();
    test_counter_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
